// File: rtl/draw_board_if.sv
// VGA timing bundle shared by the video pipeline stages.
// Carries pixel counters plus sync and blanking flags.
interface vga_if;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        hsync;
   logic        vblnk;
   logic        hblnk;

   modport master (
      output vcount, hcount, vsync, hsync, vblnk, hblnk
   );

   modport slave (
      input vcount, hcount, vsync, hsync, vblnk, hblnk
   );
endinterface

// File: rtl/draw_board.sv
// Snake board overlay: paints tiles from a sync-read tile RAM
// over the upstream pixel stream, with a 3-clk aligned pipeline.
module draw_board #(
   parameter int              BOARD_X    = 64,
   parameter int              BOARD_Y    = 32,
   parameter int              CELL_LOG2  = 4,
   parameter int              COLS       = 32,
   parameter int              ROWS       = 32,
   parameter int              RGB_B      = 12,
   parameter logic [RGB_B-1:0] COL_SNAKE1 = 12'h0F0,
   parameter logic [RGB_B-1:0] COL_SNAKE2 = 12'h00F,
   parameter logic [RGB_B-1:0] COL_FOOD   = 12'hFF0,
   parameter bit              GRID_EN    = 1'b1,
   parameter logic [RGB_B-1:0] GRID_COLOR = 12'h222,
   localparam int             AW = $clog2(COLS * ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   vga_if.slave             vga_in,
   input  logic [RGB_B-1:0] rgb_i,
   output logic [AW-1:0]    map_addr,
   input  logic [1:0]       map_data,
   vga_if.master            vga_out,
   output logic [RGB_B-1:0] rgb_o
);

   typedef struct packed {
      logic [10:0] vc;
      logic [10:0] hc;
      logic        vs;
      logic        hs;
      logic        vb;
      logic        hb;
   } tim_t;

   localparam logic [11:0] X0 = 12'(BOARD_X);
   localparam logic [11:0] X1 = 12'(BOARD_X + (COLS << CELL_LOG2));
   localparam logic [11:0] Y0 = 12'(BOARD_Y);
   localparam logic [11:0] Y1 = 12'(BOARD_Y + (ROWS << CELL_LOG2));

   tim_t             tin;
   logic             inb;
   logic             grid_n;
   logic [10:0]      hoff;
   logic [10:0]      voff;
   logic [21:0]      lin;
   logic [AW-1:0]    addr_n;
   logic [RGB_B-1:0] col_n;

   tim_t             t1, t2;
   logic             in1, in2;
   logic             grid1, grid2;
   logic [RGB_B-1:0] rgb1, rgb2;

   // Board window test, cell address and grid-line detection.
   always_comb begin
      tin = '{vga_in.vcount, vga_in.hcount, vga_in.vsync,
              vga_in.hsync, vga_in.vblnk, vga_in.hblnk};
      inb = ({1'b0, vga_in.hcount} >= X0) &&
            ({1'b0, vga_in.hcount} <  X1) &&
            ({1'b0, vga_in.vcount} >= Y0) &&
            ({1'b0, vga_in.vcount} <  Y1) &&
            !vga_in.hblnk && !vga_in.vblnk;
      hoff   = '0;
      voff   = '0;
      lin    = '0;
      addr_n = '0;
      grid_n = 1'b0;
      if (inb) begin
         hoff   = vga_in.hcount - X0[10:0];
         voff   = vga_in.vcount - Y0[10:0];
         lin    = 22'(voff >> CELL_LOG2) * 22'(COLS) +
                  22'(hoff >> CELL_LOG2);
         addr_n = lin[AW-1:0];
         grid_n = (hoff[CELL_LOG2-1:0] == '0) ||
                  (voff[CELL_LOG2-1:0] == '0);
      end
   end

   // Final colour pick: grid beats tiles, empty tiles show background.
   always_comb begin
      col_n = rgb2;
      if (in2) begin
         if (GRID_EN && grid2) begin
            col_n = GRID_COLOR;
         end else begin
            unique case (map_data)
               2'd1:    col_n = COL_SNAKE1;
               2'd2:    col_n = COL_SNAKE2;
               2'd3:    col_n = COL_FOOD;
               default: col_n = rgb2;
            endcase
         end
      end
   end

   // Three-stage pipeline; stage 2 waits for the RAM read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         map_addr       <= '0;
         t1             <= '0;
         t2             <= '0;
         in1            <= 1'b0;
         in2            <= 1'b0;
         grid1          <= 1'b0;
         grid2          <= 1'b0;
         rgb1           <= '0;
         rgb2           <= '0;
         rgb_o          <= '0;
         vga_out.vcount <= '0;
         vga_out.hcount <= '0;
         vga_out.vsync  <= 1'b0;
         vga_out.hsync  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
      end else begin
         map_addr       <= addr_n;
         t1             <= tin;
         in1            <= inb;
         grid1          <= grid_n;
         rgb1           <= rgb_i;
         t2             <= t1;
         in2            <= in1;
         grid2          <= grid1;
         rgb2           <= rgb1;
         rgb_o          <= col_n;
         vga_out.vcount <= t2.vc;
         vga_out.hcount <= t2.hc;
         vga_out.vsync  <= t2.vs;
         vga_out.hsync  <= t2.hs;
         vga_out.vblnk  <= t2.vb;
         vga_out.hblnk  <= t2.hb;
      end
   end

endmodule

// File: tb/tb_draw_board.sv
// Bench for draw_board: vector table, reset sequence and
// randomized pixels checked against a geometric board model.
module tb_draw_board;

   localparam int BX   = 64;
   localparam int BY   = 32;
   localparam int CELL = 16;
   localparam int NC   = 32;
   localparam int NR   = 32;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } pix_t;

   typedef struct packed {
      pix_t        p;
      logic        set;
      logic [1:0]  md;
      logic [9:0]  ea;
      logic [11:0] er;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] rgb_i = '0;
   logic [11:0] rgb_o;
   logic [9:0]  map_addr;
   logic [1:0]  map_data = '0;
   logic [1:0]  mem [0:NC*NR-1];

   int nchk = 0;
   int nerr = 0;
   pix_t hist[$];

   vga_if vin ();
   vga_if vout ();

   draw_board dut (
      .clk      (clk),
      .rst      (rst),
      .vga_in   (vin),
      .rgb_i    (rgb_i),
      .map_addr (map_addr),
      .map_data (map_data),
      .vga_out  (vout),
      .rgb_o    (rgb_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) map_data <= mem[map_addr];

   function automatic bit on_board(pix_t p);
      int dx = int'(p.h) - BX;
      int dy = int'(p.v) - BY;
      return !p.hb && !p.vb && dx >= 0 && dx < NC * CELL &&
             dy >= 0 && dy < NR * CELL;
   endfunction

   function automatic logic [9:0] ref_addr(pix_t p);
      int dx = int'(p.h) - BX;
      int dy = int'(p.v) - BY;
      if (!on_board(p)) return 10'd0;
      return 10'((dy / CELL) * NC + dx / CELL);
   endfunction

   function automatic logic [11:0] ref_rgb(pix_t p);
      int dx = int'(p.h) - BX;
      int dy = int'(p.v) - BY;
      if (!on_board(p)) return p.rgb;
      if (dx % CELL == 0 || dy % CELL == 0) return 12'h222;
      case (mem[(dy / CELL) * NC + dx / CELL])
         2'd1:    return 12'h0F0;
         2'd2:    return 12'h00F;
         2'd3:    return 12'hFF0;
         default: return p.rgb;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step(pix_t p);
      pix_t q;
      vin.hcount = p.h;
      vin.vcount = p.v;
      vin.hsync  = p.hs;
      vin.vsync  = p.vs;
      vin.hblnk  = p.hb;
      vin.vblnk  = p.vb;
      rgb_i      = p.rgb;
      @(posedge clk);
      #1;
      chk("map_addr", 32'(map_addr), 32'(ref_addr(p)));
      hist.push_front(p);
      if (hist.size() > 3) void'(hist.pop_back());
      if (hist.size() == 3) begin
         q = hist[2];
         chk("rgb_o", 32'(rgb_o), 32'(ref_rgb(q)));
         chk("vout_h", 32'(vout.hcount), 32'(q.h));
         chk("vout_v", 32'(vout.vcount), 32'(q.v));
         chk("vout_flags",
             32'({vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
             32'({q.hs, q.vs, q.hb, q.vb}));
      end else begin
         chk("early_rgb", 32'(rgb_o), 32'd0);
         chk("early_vout", 32'({vout.hcount, vout.vcount,
             vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'd0);
      end
   endtask

   function automatic pix_t rnd_pix();
      pix_t p;
      p.h   = 11'($urandom_range(0, 799));
      p.v   = 11'($urandom_range(0, 599));
      p.hs  = 1'($urandom);
      p.vs  = 1'($urandom);
      p.hb  = ($urandom_range(0, 9) == 0);
      p.vb  = ($urandom_range(0, 19) == 0);
      p.rgb = 12'($urandom);
      return p;
   endfunction

   function automatic pix_t filler();
      pix_t p;
      p     = '0;
      p.h   = 11'd700;
      p.v   = 11'd580;
      p.hb  = 1'b1;
      p.vb  = 1'b1;
      p.rgb = 12'($urandom);
      return p;
   endfunction

   task automatic chk_zero(string nm);
      chk({nm, "_rgb"}, 32'(rgb_o), 32'd0);
      chk({nm, "_addr"}, 32'(map_addr), 32'd0);
      chk({nm, "_vout"}, 32'({vout.hcount, vout.vcount, vout.hsync,
          vout.vsync, vout.hblnk, vout.vblnk}), 32'd0);
   endtask

   vec_t vecs [13];
   pix_t sp;

   initial begin
      vin.hcount = '0;
      vin.vcount = '0;
      vin.hsync  = 1'b0;
      vin.vsync  = 1'b0;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      for (int i = 0; i < NC * NR; i++) mem[i] = 2'd0;

      vecs[0]  = '{'{11'd100, 11'd50,  1'b0, 1'b0, 1'b0, 1'b0, 12'h123},
                   1'b1, 2'd1, 10'd34,   12'h0F0};
      vecs[1]  = '{'{11'd147, 11'd153, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456},
                   1'b1, 2'd2, 10'd229,  12'h00F};
      vecs[2]  = '{'{11'd575, 11'd543, 1'b0, 1'b1, 1'b0, 1'b0, 12'h789},
                   1'b1, 2'd3, 10'd1023, 12'hFF0};
      vecs[3]  = '{'{11'd63,  11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC},
                   1'b0, 2'd0, 10'd0,    12'hABC};
      vecs[4]  = '{'{11'd576, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'hDEF},
                   1'b0, 2'd0, 10'd0,    12'hDEF};
      vecs[5]  = '{'{11'd64,  11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111},
                   1'b1, 2'd2, 10'd128,  12'h222};
      vecs[6]  = '{'{11'd96,  11'd80,  1'b0, 1'b0, 1'b0, 1'b0, 12'h333},
                   1'b1, 2'd3, 10'd98,   12'h222};
      vecs[7]  = '{'{11'd97,  11'd81,  1'b0, 1'b0, 1'b0, 1'b0, 12'h444},
                   1'b1, 2'd3, 10'd98,   12'hFF0};
      vecs[8]  = '{'{11'd120, 11'd90,  1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5},
                   1'b1, 2'd0, 10'd99,   12'h5A5};
      vecs[9]  = '{'{11'd120, 11'd90,  1'b1, 1'b0, 1'b1, 1'b0, 12'h3C3},
                   1'b0, 2'd0, 10'd0,    12'h3C3};
      vecs[10] = '{'{11'd150, 11'd150, 1'b0, 1'b1, 1'b0, 1'b1, 12'h0F1},
                   1'b0, 2'd0, 10'd0,    12'h0F1};
      vecs[11] = '{'{11'd100, 11'd31,  1'b0, 1'b0, 1'b0, 1'b0, 12'h777},
                   1'b0, 2'd0, 10'd0,    12'h777};
      vecs[12] = '{'{11'd100, 11'd544, 1'b0, 1'b0, 1'b0, 1'b0, 12'h888},
                   1'b0, 2'd0, 10'd0,    12'h888};

      // reset state
      #3;
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem[0] = 2'd3;

      // table vectors: pixel then two fillers, check at 3 clk
      foreach (vecs[i]) begin
         if (vecs[i].set) mem[vecs[i].ea] = vecs[i].md;
         step(vecs[i].p);
         chk($sformatf("vec%0d_addr", i), 32'(map_addr),
             32'(vecs[i].ea));
         step(filler());
         step(filler());
         chk($sformatf("vec%0d_rgb", i), 32'(rgb_o), 32'(vecs[i].er));
         chk($sformatf("vec%0d_h", i), 32'(vout.hcount),
             32'(vecs[i].p.h));
      end

      // randomized tile map and pixels
      for (int i = 0; i < NC * NR; i++) mem[i] = 2'($urandom);
      for (int i = 0; i < 1500; i++) step(rnd_pix());

      // async reset mid-line, then clean resume
      for (int i = 0; i < 5; i++) begin
         sp     = '0;
         sp.h   = 11'(200 + i);
         sp.v   = 11'd200;
         sp.rgb = 12'($urandom);
         step(sp);
      end
      #3;
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      @(posedge clk);
      #1;
      chk_zero("midrst_hold");
      rst = 1'b0;
      hist.delete();
      for (int i = 0; i < 6; i++) begin
         sp     = '0;
         sp.h   = 11'(210 + i);
         sp.v   = 11'd200;
         sp.rgb = 12'($urandom);
         step(sp);
      end

      // one row swept across both board edges
      for (int h = 56; h < 590; h++) begin
         sp     = '0;
         sp.h   = 11'(h);
         sp.v   = 11'd300;
         sp.hs  = (h > 580);
         sp.rgb = 12'($urandom);
         step(sp);
      end

      for (int i = 0; i < 1500; i++) step(rnd_pix());

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
